// File: rtl/vc_regfile_pkg.sv
// Shared constants and width/lane helpers for the vc_regfile family.
package vc_regfile_pkg;

  localparam int unsigned c_max_rd_ports = 4;

  function automatic int unsigned addr_nbits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_nbits(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Bit offset of lane k in a bus packed as k*w +: w.
  function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/vc_regfile_scoreboard.sv
// Pending-write scoreboard: per-entry pending bits, pending count and sticky error.
module vc_regfile_scoreboard
  import vc_regfile_pkg::*;
#(
  parameter int unsigned p_num_entries = 32,
  parameter bit          p_zero_reg    = 1'b1,
  localparam int unsigned c_addr_nbits = addr_nbits(p_num_entries),
  localparam int unsigned c_cnt_nbits  = cnt_nbits(p_num_entries)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rsv_en,
  input  logic [c_addr_nbits-1:0]  rsv_addr,
  input  logic                     wr_en,
  input  logic [c_addr_nbits-1:0]  wr_addr,
  output logic [p_num_entries-1:0] pend,
  output logic [c_cnt_nbits-1:0]   num_pend,
  output logic                     err
);

  localparam logic [c_cnt_nbits-1:0] c_one = c_cnt_nbits'(1);

  logic                     rsv_live;
  logic                     wr_live;
  logic                     same;
  logic                     inc;
  logic                     dec;
  logic                     err_set;
  logic [p_num_entries-1:0] pend_next;
  logic [c_cnt_nbits-1:0]   cnt_next;

  always_comb begin
    rsv_live = rsv_en && !(p_zero_reg && rsv_addr == '0);
    wr_live  = wr_en  && !(p_zero_reg && wr_addr  == '0);
    same     = rsv_live && wr_live && (rsv_addr == wr_addr);

    // Reservation applied after the write so a same-address pair leaves the entry pending.
    pend_next = pend;
    if (wr_live)  pend_next[wr_addr]  = 1'b0;
    if (rsv_live) pend_next[rsv_addr] = 1'b1;

    inc     = rsv_live && !pend[rsv_addr];
    dec     = wr_live && pend[wr_addr] && !same;
    err_set = rsv_live && pend[rsv_addr] && !same;

    cnt_next = num_pend;
    if (inc && !dec)      cnt_next = num_pend + c_one;
    else if (dec && !inc) cnt_next = num_pend - c_one;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend     <= '0;
      num_pend <= '0;
      err      <= 1'b0;
    end else begin
      pend     <= pend_next;
      num_pend <= cnt_next;
      err      <= err | err_set;
    end
  end

endmodule

// File: rtl/vc_sb_regfile_nr1w.sv
// N-read/1-write register file with integrated pending-write scoreboard.
// Define VC_REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module vc_sb_regfile_nr1w
  import vc_regfile_pkg::*;
#(
  parameter int unsigned             p_data_nbits  = 32,
  parameter int unsigned             p_num_entries = 32,
  parameter int unsigned             p_num_rd      = 2,
  parameter logic [p_data_nbits-1:0] p_reset_value = '0,
  parameter bit                      p_zero_reg    = 1'b1,
  localparam int unsigned c_addr_nbits = addr_nbits(p_num_entries),
  localparam int unsigned c_cnt_nbits  = cnt_nbits(p_num_entries)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [p_num_rd*c_addr_nbits-1:0] rd_addr,
  output logic [p_num_rd*p_data_nbits-1:0] rd_data,
  output logic [p_num_rd-1:0]              rd_pend,
  input  logic                             rsv_en,
  input  logic [c_addr_nbits-1:0]          rsv_addr,
  input  logic                             wr_en,
  input  logic [c_addr_nbits-1:0]          wr_addr,
  input  logic [p_data_nbits-1:0]          wr_data,
  output logic [c_cnt_nbits-1:0]           num_pend,
  output logic                             err
);

  logic [p_data_nbits-1:0]  mem [p_num_entries];
  logic [p_num_entries-1:0] pend;
  logic                     wr_live;

  assign wr_live = wr_en && !(p_zero_reg && wr_addr == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < p_num_entries; i++) mem[i] <= p_reset_value;
    end else if (wr_live) begin
      mem[wr_addr] <= wr_data;
    end
  end

  vc_regfile_scoreboard #(
    .p_num_entries (p_num_entries),
    .p_zero_reg    (p_zero_reg)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .pend     (pend),
    .num_pend (num_pend),
    .err      (err)
  );

  for (genvar k = 0; k < p_num_rd; k++) begin : g_rd
    logic [c_addr_nbits-1:0] addr;
    logic [p_data_nbits-1:0] data;
    logic                    pnd;

    assign addr = rd_addr[lane_lsb(k, c_addr_nbits) +: c_addr_nbits];

    always_comb begin
      data = mem[addr];
      pnd  = pend[addr];
`ifdef VC_REGFILE_BYPASS_EN
      if (wr_live && wr_addr == addr) begin
        data = wr_data;
        pnd  = 1'b0;
      end
`endif
      if (p_zero_reg && addr == '0) begin
        data = '0;
        pnd  = 1'b0;
      end
    end

    assign rd_data[lane_lsb(k, p_data_nbits) +: p_data_nbits] = data;
    assign rd_pend[k] = pnd;
  end

endmodule
